// File: rtl/niu_tx_arbiter_pkg.sv
// Shared NoC constants and helpers for the NIU tx write-slot arbiter.
package niu_tx_arbiter_pkg;

    localparam int unsigned NOC_MAX_PKT_LEN   = 35;
    localparam int unsigned NOC_LEN_W         = 8;
    localparam int unsigned NOC_TXBUF_SPACE_W = 9;

    // A length byte is legal when it is non-zero and no larger than max_len.
    function automatic logic len_legal(input logic [NOC_LEN_W-1:0] len,
                                       input int unsigned          max_len);
        return (len != '0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/niu_tx_arbiter_rr_pick.sv
// Find-first-set starting at a pointer, wrapping N-1 -> 0; one-hot and index result.
module niu_tx_arbiter_rr_pick #(
    parameter int unsigned N     = 1,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Walk the requesters in rotated order and keep the first hit.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (!any_o && (k == ((32'(ptr_i) + i) % N)) && req_i[k]) begin
                    any_o    = 1'b1;
                    gnt_o[k] = 1'b1;
                    idx_o    = IDX_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/niu_tx_arbiter.sv
// NIU tx buffer write-slot arbiter: forward path first (streak-limited), local ports round-robin.
module niu_tx_arbiter
    import niu_tx_arbiter_pkg::*;
#(
    parameter int unsigned PORTS          = 1,
    parameter int unsigned MAX_PKT_LEN    = NOC_MAX_PKT_LEN,
    parameter int unsigned FWD_STREAK_MAX = 4,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned SPACE_W        = NOC_TXBUF_SPACE_W
) (
    input  logic                                fclk,
    input  logic                                rst,
    input  logic                                fwd_req,
    input  logic [NOC_LEN_W-1:0]                fwd_len,
    input  logic [PORTS-1:0]                    prt_req,
    input  logic [PORTS-1:0][NOC_LEN_W-1:0]     prt_len,
    input  logic [SPACE_W-1:0]                  tx_space,
    output logic                                fwd_gnt,
    output logic [PORTS-1:0]                    prt_gnt,
    output logic [NOC_LEN_W-1:0]                gnt_len,
    output logic                                err_len,
    output logic [PORTS-1:0][CNT_W-1:0]         prt_gnt_cnt
);

    localparam int unsigned PTR_W  = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int unsigned STRK_W = $clog2(FWD_STREAK_MAX + 1);

    logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [STRK_W-1:0]             streak_q, streak_d;
    logic [PORTS-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic                          err_q, err_d;

    logic                          fwd_elig, fwd_bad;
    logic [PORTS-1:0]              prt_elig, prt_bad;
    logic [PORTS-1:0]              pick_onehot;
    logic [PTR_W-1:0]              pick_idx;
    logic                          pick_any;
    logic                          fwd_win;

    // Per-requester eligibility (legal length that fits) and illegal-length flags.
    always_comb begin
        fwd_bad  = fwd_req && !len_legal(fwd_len, MAX_PKT_LEN);
        fwd_elig = fwd_req && len_legal(fwd_len, MAX_PKT_LEN) &&
                   (32'(fwd_len) <= 32'(tx_space));
        prt_bad  = '0;
        prt_elig = '0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            prt_bad[k]  = prt_req[k] && !len_legal(prt_len[k], MAX_PKT_LEN);
            prt_elig[k] = prt_req[k] && len_legal(prt_len[k], MAX_PKT_LEN) &&
                          (32'(prt_len[k]) <= 32'(tx_space));
        end
    end

    niu_tx_arbiter_rr_pick #(
        .N     (PORTS),
        .IDX_W (PTR_W)
    ) u_rr_pick (
        .req_i (prt_elig),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_onehot),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Same-cycle grant: forward wins unless it has hit its streak limit with a port waiting.
    always_comb begin
        fwd_win = fwd_elig && ((32'(streak_q) < FWD_STREAK_MAX) || !pick_any);
        fwd_gnt = 1'b0;
        prt_gnt = '0;
        gnt_len = '0;
        if (!rst) begin
            if (fwd_win) begin
                fwd_gnt = 1'b1;
                gnt_len = fwd_len;
            end else if (pick_any) begin
                prt_gnt = pick_onehot;
                for (int unsigned k = 0; k < PORTS; k++) begin
                    if (pick_onehot[k]) begin
                        gnt_len = prt_len[k];
                    end
                end
            end
        end
    end

    // Next-state for pointer, streak, statistics and the sticky length error.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        streak_d = streak_q;
        cnt_d    = cnt_q;
        err_d    = err_q | fwd_bad | (|prt_bad);

        if (|prt_gnt) begin
            rr_ptr_d = (32'(pick_idx) == (PORTS - 1)) ? '0 : PTR_W'(pick_idx + PTR_W'(1));
        end

        if ((|prt_gnt) || !pick_any) begin
            streak_d = '0;
        end else if (fwd_gnt && (32'(streak_q) < FWD_STREAK_MAX)) begin
            streak_d = streak_q + STRK_W'(1);
        end

        for (int unsigned k = 0; k < PORTS; k++) begin
            if (prt_gnt[k] && (cnt_q[k] != '1)) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    // State register with synchronous reset taking priority.
    always_ff @(posedge fclk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            streak_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            streak_q <= streak_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_len     = err_q;
    assign prt_gnt_cnt = cnt_q;

endmodule

// File: tb/tb_niu_tx_arbiter.sv
// Self-checking bench for niu_tx_arbiter (PORTS=4, FWD_STREAK_MAX=4, CNT_W=4).
module tb_niu_tx_arbiter;

    localparam int NP   = 4;
    localparam int MAXL = 35;
    localparam int SMAX = 4;
    localparam int CMAX = 15;

    typedef struct {
        logic        rst;
        logic        fr;
        logic [7:0]  fl;
        logic [3:0]  pr;
        logic [31:0] pl;
        logic [8:0]  sp;
        logic        ef;
        logic [3:0]  ep;
        logic [7:0]  el;
    } vec_t;

    logic             fclk;
    logic             rst;
    logic             fwd_req;
    logic [7:0]       fwd_len;
    logic [3:0]       prt_req;
    logic [3:0][7:0]  prt_len;
    logic [8:0]       tx_space;
    logic             fwd_gnt;
    logic [3:0]       prt_gnt;
    logic [7:0]       gnt_len;
    logic             err_len;
    logic [3:0][3:0]  prt_gnt_cnt;

    int total;
    int bad;

    // Reference model state
    int m_ptr;
    int m_streak;
    int m_cnt[NP];
    bit m_err;

    niu_tx_arbiter #(
        .PORTS          (NP),
        .MAX_PKT_LEN    (MAXL),
        .FWD_STREAK_MAX (SMAX),
        .CNT_W          (4),
        .SPACE_W        (9)
    ) dut (
        .fclk        (fclk),
        .rst         (rst),
        .fwd_req     (fwd_req),
        .fwd_len     (fwd_len),
        .prt_req     (prt_req),
        .prt_len     (prt_len),
        .tx_space    (tx_space),
        .fwd_gnt     (fwd_gnt),
        .prt_gnt     (prt_gnt),
        .gnt_len     (gnt_len),
        .err_len     (err_len),
        .prt_gnt_cnt (prt_gnt_cnt)
    );

    initial begin
        fclk = 1'b0;
        forever #5 fclk = ~fclk;
    end

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    function automatic bit legal(input int l);
        return (l >= 1) && (l <= MAXL);
    endfunction

    function automatic vec_t mk(input logic r, input logic fr, input int fl,
                                input logic [3:0] pr, input logic [31:0] pl, input int sp,
                                input logic ef, input logic [3:0] ep, input int el);
        vec_t v;
        v.rst = r;  v.fr = fr; v.fl = 8'(fl); v.pr = pr; v.pl = pl;
        v.sp  = 9'(sp); v.ef = ef; v.ep = ep; v.el = 8'(el);
        return v;
    endfunction

    // Drive one cycle, compare against either table expectations or the model, then advance the model.
    task automatic step(input vec_t v, input bit use_tbl);
        bit fe;
        bit pe[NP];
        bit anyp;
        bit illegal;
        int e_f;
        int e_p;
        int e_l;
        int g;
        int k;
        int ln;

        @(negedge fclk);
        rst      = v.rst;
        fwd_req  = v.fr;
        fwd_len  = v.fl;
        prt_req  = v.pr;
        prt_len  = v.pl;
        tx_space = v.sp;
        #1;

        fe      = v.fr && legal(int'(v.fl)) && (int'(v.fl) <= int'(v.sp));
        illegal = v.fr && !legal(int'(v.fl));
        anyp    = 1'b0;
        for (int i = 0; i < NP; i++) begin
            ln    = int'(v.pl[8*i +: 8]);
            pe[i] = v.pr[i] && legal(ln) && (ln <= int'(v.sp));
            if (v.pr[i] && !legal(ln)) illegal = 1'b1;
            if (pe[i]) anyp = 1'b1;
        end

        e_f = 0; e_p = 0; e_l = 0; g = -1;
        if (!v.rst) begin
            if (fe && (m_streak < SMAX || !anyp)) begin
                e_f = 1;
                e_l = int'(v.fl);
            end else begin
                for (int i = 0; i < NP; i++) begin
                    k = (m_ptr + i) % NP;
                    if (g < 0 && pe[k]) g = k;
                end
                if (g >= 0) begin
                    e_p = 1 << g;
                    e_l = int'(v.pl[8*g +: 8]);
                end
            end
        end

        if (use_tbl) begin
            chk("tbl_fwd_gnt", int'(fwd_gnt), int'(v.ef));
            chk("tbl_prt_gnt", int'(prt_gnt), int'(v.ep));
            chk("tbl_gnt_len", int'(gnt_len), int'(v.el));
        end else begin
            chk("fwd_gnt", int'(fwd_gnt), e_f);
            chk("prt_gnt", int'(prt_gnt), e_p);
            chk("gnt_len", int'(gnt_len), e_l);
        end
        chk("err_len", int'(err_len), int'(m_err));
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("cnt%0d", i), int'(prt_gnt_cnt[i]), m_cnt[i]);
        end

        if (v.rst) begin
            m_ptr = 0; m_streak = 0; m_err = 1'b0;
            for (int i = 0; i < NP; i++) m_cnt[i] = 0;
        end else begin
            if (illegal) m_err = 1'b1;
            if (g >= 0) begin
                m_ptr = (g + 1) % NP;
                if (m_cnt[g] < CMAX) m_cnt[g]++;
            end
            if (g >= 0 || !anyp) m_streak = 0;
            else if (e_f == 1 && m_streak < SMAX) m_streak++;
        end
    endtask

    function automatic logic [7:0] rand_len();
        int r;
        r = $urandom_range(0, 59);
        if (r == 0) return 8'd0;
        if (r == 1) return 8'($urandom_range(36, 255));
        return 8'($urandom_range(1, MAXL));
    endfunction

    vec_t tbl[$];
    vec_t v;

    initial begin
        total = 0; bad = 0;
        m_ptr = 0; m_streak = 0; m_err = 1'b0;
        for (int i = 0; i < NP; i++) m_cnt[i] = 0;
        rst = 1'b1; fwd_req = 1'b0; fwd_len = '0; prt_req = '0; prt_len = '0; tx_space = '0;

        // Reset cycles with requests present: grants must stay low.
        tbl.push_back(mk(1, 1, 8, 4'hF, 32'h08080808, 256, 0, 4'h0, 0));
        tbl.push_back(mk(1, 0, 0, 4'h0, 32'h0,        256, 0, 4'h0, 0));
        // Round-robin over four busy ports.
        tbl.push_back(mk(0, 0, 0, 4'hF, 32'h08080808, 256, 0, 4'h1, 8));
        tbl.push_back(mk(0, 0, 0, 4'hF, 32'h08080808, 256, 0, 4'h2, 8));
        tbl.push_back(mk(0, 0, 0, 4'hF, 32'h08080808, 256, 0, 4'h4, 8));
        tbl.push_back(mk(0, 0, 0, 4'hF, 32'h08080808, 256, 0, 4'h8, 8));
        tbl.push_back(mk(0, 0, 0, 4'hF, 32'h08080808, 256, 0, 4'h1, 8));
        // Forward streak limit: four fwd, one port 2, fwd again.
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1, 20, 4'h4, 32'h000A0000, 256, 1, 4'h0, 20));
        tbl.push_back(mk(0, 1, 20, 4'h4, 32'h000A0000, 256, 0, 4'h4, 10));
        tbl.push_back(mk(0, 1, 20, 4'h4, 32'h000A0000, 256, 1, 4'h0, 20));
        // Space boundary: len 9 fits in 9, fwd 12 does not; then nothing fits in 8.
        tbl.push_back(mk(0, 1, 12, 4'h2, 32'h00000900, 9, 0, 4'h2, 9));
        tbl.push_back(mk(0, 1, 12, 4'h2, 32'h00000900, 8, 0, 4'h0, 0));
        tbl.push_back(mk(0, 1, 12, 4'h2, 32'h00000900, 8, 0, 4'h0, 0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);
        chk("space_no_err", int'(err_len), 0);

        // Illegal lengths: never granted, sticky error, cleared by reset.
        step(mk(0, 0, 0, 4'h1, 32'h08080800, 256, 0, 4'h0, 0), 1'b1);
        step(mk(0, 0, 0, 4'h1, 32'h08080828, 256, 0, 4'h0, 0), 1'b1);
        chk("err_set", int'(err_len), 1);
        step(mk(0, 0, 0, 4'h0, 32'h0,        256, 0, 4'h0, 0), 1'b1);
        chk("err_sticky", int'(err_len), 1);
        step(mk(1, 0, 0, 4'h0, 32'h0,        256, 0, 4'h0, 0), 1'b1);
        step(mk(0, 0, 0, 4'h0, 32'h0,        256, 0, 4'h0, 0), 1'b1);
        chk("err_cleared", int'(err_len), 0);

        // Mid-stream reset with rr_ptr=2, streak=3.
        step(mk(0, 0, 0, 4'h2, 32'h00000500, 256, 0, 4'h2, 5), 1'b1);
        for (int i = 0; i < 3; i++)
            step(mk(0, 1, 5, 4'h4, 32'h00050000, 256, 1, 4'h0, 5), 1'b1);
        step(mk(1, 1, 5, 4'hF, 32'h05050505, 256, 0, 4'h0, 0), 1'b1);
        step(mk(0, 0, 0, 4'hF, 32'h05050505, 256, 0, 4'h1, 5), 1'b1);
        chk("rst_cnt1", int'(prt_gnt_cnt[1]), 0);

        // Counter saturation on port 0.
        for (int i = 0; i < 20; i++)
            step(mk(0, 0, 0, 4'h1, 32'h00000008, 256, 0, 4'h1, 8), 1'b1);
        step(mk(0, 0, 0, 4'h0, 32'h0, 256, 0, 4'h0, 0), 1'b1);
        chk("cnt_sat", int'(prt_gnt_cnt[0]), 15);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            v.rst = ($urandom_range(0, 119) == 0);
            v.fr  = 1'($urandom_range(0, 1));
            v.fl  = rand_len();
            v.pr  = 4'($urandom);
            for (int i = 0; i < NP; i++) v.pl[8*i +: 8] = rand_len();
            v.sp  = ($urandom_range(0, 1) == 1) ? 9'd256 : 9'($urandom_range(0, 40));
            v.ef  = 1'b0; v.ep = '0; v.el = '0;
            step(v, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
